// File: rtl/enc2_pkg.sv
// Shared widths, frame field offsets and the key-to-mask expansion used by
// the encryptor and by any decrypt model that has to undo it.
package enc2_pkg;

    localparam int KEY_W   = 11;
    localparam int MSG_W   = 60;
    localparam int CT_W    = 61;
    localparam int TAG_W   = 6;
    localparam int FRAME_W = 78;

    localparam int KEY_LSB = 67;
    localparam int CT_LSB  = 6;
    localparam int TAG_LSB = 0;

    // Key replicated across the message width, middle two copies inverted.
    function automatic logic [MSG_W-1:0] expand_mask(input logic [KEY_W-1:0] r);
        return {r[4:0], r, ~r, ~r, r, r};
    endfunction

endpackage

// File: rtl/enc2_lfsr11.sv
// 11-bit Fibonacci key generator (taps 10 and 8); steps only when adv is high.
module enc2_lfsr11
    import enc2_pkg::*;
#(
    parameter logic [KEY_W-1:0] SEED = 11'h5A5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             adv,
    output logic [KEY_W-1:0] state
);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= SEED;
        end else if (adv) begin
            state <= {state[9:0], state[10] ^ state[8]};
        end
    end

endmodule

// File: rtl/encrypt_function_2.sv
// Two-stage streaming encryptor: frame = {key, {msg,0} + mask(key), tag}.
// Sequence tag in frame bits [5:0] is built only when ENC2_SEQ_TAG_EN is defined.
module encrypt_function_2
    import enc2_pkg::*;
#(
    parameter logic [KEY_W-1:0] SEED = 11'h5A5
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    input  logic [MSG_W-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [FRAME_W-1:0] out_data,
    input  logic               out_ready
);

    // Handshake: a transfer happens on an edge where valid && ready; a
    // producer holds valid/data until then, and out_data is held while stalled.
    logic               s1_valid;
    logic [MSG_W-1:0]   s1_data;
    logic [KEY_W-1:0]   s1_key;
    logic [KEY_W-1:0]   key;
    logic [TAG_W-1:0]   frame_tag;
    logic [CT_W-1:0]    ct;
    logic               s2_load;
    logic               accept;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    enc2_lfsr11 #(.SEED(SEED)) u_lfsr (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .adv   (accept),
        .state (key)
    );

`ifdef ENC2_SEQ_TAG_EN
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            tag    <= '0;
            s1_tag <= '0;
        end else if (accept) begin
            tag    <= tag + 1'b1;
            s1_tag <= tag;
        end
    end

    assign frame_tag = s1_tag;
`else
    assign frame_tag = '0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_key   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_data <= in_data;
                s1_key  <= key;
            end
        end
    end

    // Carry out of bit 60 is dropped; decryption subtracts modulo 2^61.
    assign ct = {s1_data, 1'b0} + {1'b0, expand_mask(s1_key)};

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= {s1_key, ct, frame_tag};
            end
        end
    end

endmodule
